// File: rtl/cond_flag_stage.sv
// Execute->Memory stage: holds the NZCV flag register and evaluates the ARM condition field.
// It gates failed-condition writes and registers results into M. Define COND_SQUASH_CNT_EN to add the SquashCnt output.
module cond_flag_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ExValid,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [3:0]        Cond,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [3:0]        ALUFlags,
    input  logic [REG_AW-1:0] WA3,
    output logic [3:0]        Flags,
    output logic              CondEx,
    output logic              ValidM,
    output logic              PCSrcM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [REG_AW-1:0] WA3M
`ifdef COND_SQUASH_CNT_EN
    ,
    output logic [31:0]       SquashCnt
`endif
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic take;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];

    // Condition is judged on the registered flags only; a flag-setting
    // instruction affects the condition of the instruction after it.
    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            4'b0000: CondEx = flag_z;
            4'b0001: CondEx = ~flag_z;
            4'b0010: CondEx = flag_c;
            4'b0011: CondEx = ~flag_c;
            4'b0100: CondEx = flag_n;
            4'b0101: CondEx = ~flag_n;
            4'b0110: CondEx = flag_v;
            4'b0111: CondEx = ~flag_v;
            4'b1000: CondEx = flag_c & ~flag_z;
            4'b1001: CondEx = ~flag_c | flag_z;
            4'b1010: CondEx = (flag_n == flag_v);
            4'b1011: CondEx = (flag_n != flag_v);
            4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
            4'b1101: CondEx = flag_z | (flag_n != flag_v);
            default: CondEx = 1'b1;
        endcase
    end

    assign take = ExValid & CondEx & ~Stall & ~Flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= 4'b0000;
        end else begin
            if (take && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (take && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Flush outranks Stall; on flush the data fields simply hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ValidM     <= 1'b0;
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUResultM <= '0;
            WA3M       <= '0;
        end else if (Flush) begin
            ValidM    <= 1'b0;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (!Stall) begin
            ValidM     <= ExValid;
            PCSrcM     <= ExValid & CondEx & PCS;
            RegWriteM  <= ExValid & CondEx & RegW & ~NoWrite;
            MemWriteM  <= ExValid & CondEx & MemW;
            ALUResultM <= ALUResult;
            WA3M       <= WA3;
        end
    end

`ifdef COND_SQUASH_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            SquashCnt <= 32'd0;
        end else if (ExValid && !CondEx && !Stall && !Flush && (SquashCnt != 32'hFFFF_FFFF)) begin
            SquashCnt <= SquashCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cond_flag_stage.sv
// Directed bench for cond_flag_stage: the driver queues expected M-stage records,
// and the monitor pops and compares one record after every clock edge.
module tb_cond_flag_stage;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ExValid = 1'b0, Stall = 1'b0, Flush = 1'b0;
    logic [3:0]    Cond = 4'h0;
    logic [1:0]    FlagW = 2'b00;
    logic          PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
    logic [DW-1:0] ALUResult = '0;
    logic [3:0]    ALUFlags = 4'h0;
    logic [AW-1:0] WA3 = '0;
    logic [3:0]    Flags;
    logic          CondEx, ValidM, PCSrcM, RegWriteM, MemWriteM;
    logic [DW-1:0] ALUResultM;
    logic [AW-1:0] WA3M;
`ifdef COND_SQUASH_CNT_EN
    logic [31:0]   SquashCnt;
    int            exp_sq = 0;
`endif

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    // record: {care_data, valid, pcs, regw, memw, flags[3:0], result[31:0], wa3[3:0]}
    logic [44:0] exp_q[$];
    logic [44:0] last_exp = '0;

    always #5 clk = ~clk;

    cond_flag_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ExValid(ExValid), .Stall(Stall), .Flush(Flush),
        .Cond(Cond), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags), .WA3(WA3), .Flags(Flags), .CondEx(CondEx),
        .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WA3M(WA3M)
`ifdef COND_SQUASH_CNT_EN
        , .SquashCnt(SquashCnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after each edge out of reset, one expected record is due.
    always @(posedge clk) begin
        if (mon_en && reset_n) begin
            logic [44:0] e;
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL m_record: got empty queue expected a record at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("m_ctrl", {60'd0, ValidM, PCSrcM, RegWriteM, MemWriteM}, {60'd0, e[43:40]});
                check("flags", {60'd0, Flags}, {60'd0, e[39:36]});
                if (e[44]) check("m_data", {28'd0, ALUResultM, WA3M}, {28'd0, e[35:0]});
            end
        end
    end

    // Called at a negedge; drives one EX-stage cycle and returns at the next negedge.
    task automatic issue(input logic v, input logic s, input logic f, input logic [3:0] cond,
                         input logic [1:0] fw, input logic pcs, input logic regw, input logic memw,
                         input logic nw, input logic [31:0] res, input logic [3:0] af,
                         input logic [3:0] wa, input logic e_cx, input logic [3:0] e_fl,
                         input logic [2:0] e_ctl);
        logic [44:0] e;
        ExValid = v; Stall = s; Flush = f; Cond = cond; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw; NoWrite = nw;
        ALUResult = res; ALUFlags = af; WA3 = wa;
        if (f)      e = {1'b0, 1'b0, 3'b000, e_fl, last_exp[35:0]};
        else if (s) e = {last_exp[44:40], e_fl, last_exp[35:0]};
        else        e = {1'b1, v, e_ctl, e_fl, res, wa};
        last_exp = e;
        exp_q.push_back(e);
`ifdef COND_SQUASH_CNT_EN
        if (v && !e_cx && !s && !f) exp_sq++;
`endif
        #1;
        check("cond_ex", {63'd0, CondEx}, {63'd0, e_cx});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("reset_out", {18'd0, Flags, ValidM, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        //     v  s  f  cond   fw     pcs  regw memw nw  result      aluflg  wa     cx  flags   ctl
        issue(1, 0, 0, 4'hE, 2'b11, 0, 1, 0, 1, 32'h0000_0011, 4'b0110, 4'd3, 1, 4'b0110, 3'b000); // CMP
        issue(1, 0, 0, 4'h0, 2'b00, 0, 1, 0, 0, 32'h0000_0022, 4'b0000, 4'd5, 1, 4'b0110, 3'b010); // EQ
        issue(1, 0, 0, 4'h1, 2'b11, 1, 1, 1, 0, 32'h0000_0033, 4'b1111, 4'd6, 0, 4'b0110, 3'b000); // NE fails
        issue(1, 0, 0, 4'h8, 2'b00, 0, 1, 0, 0, 32'h0000_0044, 4'b0000, 4'd7, 0, 4'b0110, 3'b000); // HI
        issue(1, 0, 0, 4'h9, 2'b00, 0, 0, 1, 0, 32'h0000_0055, 4'b0000, 4'd8, 1, 4'b0110, 3'b001); // LS
        issue(1, 0, 0, 4'h2, 2'b00, 1, 1, 0, 0, 32'hDEAD_BEEF, 4'b0000, 4'd15, 1, 4'b0110, 3'b110); // CS
        issue(0, 0, 0, 4'hE, 2'b11, 1, 1, 1, 0, 32'h0000_0077, 4'b1001, 4'd9, 1, 4'b0110, 3'b000); // bubble
        issue(1, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 4'd1, 1, 4'b0000, 3'b000);
        issue(1, 0, 0, 4'hE, 2'b10, 0, 1, 0, 0, 32'h0000_0088, 4'b1111, 4'd2, 1, 4'b1100, 3'b010); // NZ only
        issue(1, 0, 0, 4'hA, 2'b00, 0, 1, 0, 0, 32'h0000_0099, 4'b0000, 4'd3, 0, 4'b1100, 3'b000); // GE
        issue(1, 0, 0, 4'hD, 2'b00, 0, 1, 0, 0, 32'h0000_00AA, 4'b0000, 4'd4, 1, 4'b1100, 3'b010); // LE
        issue(1, 0, 0, 4'hC, 2'b00, 0, 1, 0, 0, 32'h0000_00BB, 4'b0000, 4'd5, 0, 4'b1100, 3'b000); // GT
        issue(1, 0, 0, 4'hB, 2'b00, 0, 0, 1, 0, 32'h0000_00CC, 4'b0000, 4'd6, 1, 4'b1100, 3'b001); // LT
        issue(1, 0, 0, 4'h4, 2'b00, 0, 1, 0, 0, 32'h0000_00DD, 4'b0000, 4'd7, 1, 4'b1100, 3'b010); // MI
        issue(1, 0, 0, 4'h5, 2'b00, 0, 1, 0, 0, 32'h0000_00EE, 4'b0000, 4'd8, 0, 4'b1100, 3'b000); // PL
        issue(1, 0, 0, 4'hE, 2'b01, 0, 0, 0, 0, 32'h0000_00FF, 4'b0011, 4'd9, 1, 4'b1111, 3'b000); // CV only
        issue(1, 0, 0, 4'h6, 2'b00, 0, 1, 0, 0, 32'h0000_0101, 4'b0000, 4'd10, 1, 4'b1111, 3'b010); // VS
        issue(1, 0, 0, 4'h7, 2'b11, 0, 1, 0, 0, 32'h0000_0202, 4'b0000, 4'd11, 0, 4'b1111, 3'b000); // VC
        issue(1, 0, 0, 4'h3, 2'b00, 0, 1, 0, 0, 32'h0000_0303, 4'b0000, 4'd12, 0, 4'b1111, 3'b000); // CC
        issue(1, 0, 0, 4'hF, 2'b00, 0, 1, 0, 0, 32'h0000_0404, 4'b0000, 4'd13, 1, 4'b1111, 3'b010); // 1111
        issue(1, 1, 0, 4'hE, 2'b11, 0, 1, 0, 0, 32'h0000_0505, 4'b0000, 4'd14, 1, 4'b1111, 3'b000); // stall
        issue(1, 1, 0, 4'hE, 2'b11, 1, 0, 1, 0, 32'h0000_0606, 4'b1001, 4'd0, 1, 4'b1111, 3'b000); // stall
        issue(1, 1, 1, 4'hE, 2'b11, 0, 1, 0, 0, 32'h0000_0707, 4'b1001, 4'd1, 1, 4'b1111, 3'b000); // stall+flush
        issue(1, 0, 1, 4'hE, 2'b11, 0, 1, 0, 0, 32'h0000_0808, 4'b0000, 4'd2, 1, 4'b1111, 3'b000); // flush
        issue(1, 0, 0, 4'hE, 2'b00, 0, 1, 0, 0, 32'h0000_0909, 4'b0000, 4'd3, 1, 4'b1111, 3'b010);
        issue(1, 1, 0, 4'h7, 2'b00, 0, 1, 0, 0, 32'h0000_0A0A, 4'b0000, 4'd4, 0, 4'b1111, 3'b000); // failed, stalled
`ifdef COND_SQUASH_CNT_EN
        check("squash_cnt", {32'd0, SquashCnt}, {32'd0, exp_sq[31:0]});
`endif
        issue(1, 0, 0, 4'hE, 2'b00, 1, 1, 1, 0, 32'hCAFE_F00D, 4'b0000, 4'd6, 1, 4'b1111, 3'b111);
        // async reset while a valid instruction is stalled
        mon_en = 1'b0;
        ExValid = 1'b1; Stall = 1'b1; Flush = 1'b0; Cond = 4'hE; FlagW = 2'b11; RegW = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {18'd0, Flags, ValidM, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M}, 64'd0);
`ifdef COND_SQUASH_CNT_EN
        check("squash_reset", {32'd0, SquashCnt}, 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("after_release", {18'd0, Flags, ValidM, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M}, 64'd0);
        check("queue_drained", {32'd0, exp_q.size()}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
